// File: rtl/cache_pkg.sv
// Shared types for the direct-mapped write-through data cache:
// FSM state encoding, default geometry and the tag-hit compare.
package cache_pkg;

   localparam int unsigned DEF_BIT_WIDTH  = 32;
   localparam int unsigned DEF_INDEX_BITS = 6;
   localparam int unsigned DEF_TAG_BITS   = DEF_BIT_WIDTH - DEF_INDEX_BITS;

   // Tags are zero-extended to this width so one compare serves any geometry.
   localparam int unsigned MAX_TAG_BITS = 64;
   typedef logic [MAX_TAG_BITS-1:0] tag_ext_t;

   typedef enum logic [1:0] {
      IDLE,
      RMISS,
      WRITE
   } state_t;

   function automatic logic tag_hit(input logic     valid,
                                    input tag_ext_t line_tag,
                                    input tag_ext_t req_tag);
      return valid && (line_tag == req_tag);
   endfunction

endpackage

// File: rtl/cache_line_store.sv
// Line storage for the data cache: clearable valid bits plus unreset tag and
// data arrays, one combinational read port and one synchronous write port.
module cache_line_store #(
   parameter int unsigned INDEX_BITS = 6,
   parameter int unsigned TAG_BITS   = 26,
   parameter int unsigned DATA_BITS  = 32
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic [INDEX_BITS-1:0] rd_index,
   output logic                  rd_valid,
   output logic [TAG_BITS-1:0]   rd_tag,
   output logic [DATA_BITS-1:0]  rd_data,
   input  logic                  wr_en,
   input  logic [INDEX_BITS-1:0] wr_index,
   input  logic [TAG_BITS-1:0]   wr_tag,
   input  logic [DATA_BITS-1:0]  wr_data,
   input  logic                  wr_valid
);

   localparam int unsigned LINES = 2 ** INDEX_BITS;

   logic [LINES-1:0]     valid;
   logic [TAG_BITS-1:0]  tags  [LINES];
   logic [DATA_BITS-1:0] datas [LINES];

   always_ff @(posedge clk) begin
      if (clear) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_index] <= wr_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tags[wr_index]  <= wr_tag;
         datas[wr_index] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tags[rd_index];
   assign rd_data  = datas[rd_index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller:
// zero-wait read hits, fixed-latency read misses and writes to backing memory.
module dcache_ctrl
   import cache_pkg::*;
#(
   parameter int unsigned BIT_WIDTH   = DEF_BIT_WIDTH,
   parameter int unsigned INDEX_BITS  = DEF_INDEX_BITS,
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [BIT_WIDTH-1:0] cpu_addr,
   input  logic [BIT_WIDTH-1:0] cpu_wdata,
   output logic [BIT_WIDTH-1:0] cpu_rdata,
   output logic                 cpu_ready,
   output logic                 memwrite,
   output logic [BIT_WIDTH-1:0] addr,
   output logic [BIT_WIDTH-1:0] writedata,
   input  logic [BIT_WIDTH-1:0] memdata
);

   localparam int unsigned TAG_BITS = BIT_WIDTH - INDEX_BITS;
   localparam int unsigned CNT_BITS = $clog2(MEM_LATENCY + 1);

   typedef logic [CNT_BITS-1:0] cnt_t;

   state_t               state, state_nx;
   cnt_t                 cnt, cnt_nx;
   logic [BIT_WIDTH-1:0] addr_nx, wdata_nx;
   logic [BIT_WIDTH-1:0] lk_addr;
   logic [INDEX_BITS-1:0] lk_index;
   logic [TAG_BITS-1:0]  lk_tag;
   logic                 line_valid;
   logic [TAG_BITS-1:0]  line_tag;
   logic [BIT_WIDTH-1:0] line_data;
   logic                 hit;
   logic                 fill_we;
   logic [BIT_WIDTH-1:0] fill_data;
   logic                 last_cycle;

   // In IDLE the lookup follows the CPU address; otherwise the latched one.
   assign lk_addr  = (state == IDLE) ? cpu_addr : addr;
   assign lk_index = lk_addr[INDEX_BITS-1:0];
   assign lk_tag   = lk_addr[BIT_WIDTH-1:INDEX_BITS];
   assign hit      = tag_hit(line_valid, tag_ext_t'(line_tag), tag_ext_t'(lk_tag));
   assign last_cycle = (cnt == cnt_t'(MEM_LATENCY));

   cache_line_store #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS),
      .DATA_BITS  (BIT_WIDTH)
   ) u_lines (
      .clk      (clk),
      .clear    (!rst_n),
      .rd_index (lk_index),
      .rd_valid (line_valid),
      .rd_tag   (line_tag),
      .rd_data  (line_data),
      .wr_en    (fill_we),
      .wr_index (lk_index),
      .wr_tag   (lk_tag),
      .wr_data  (fill_data),
      .wr_valid (1'b1)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         addr      <= '0;
         writedata <= '0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         addr      <= addr_nx;
         writedata <= wdata_nx;
      end
   end

   // Outputs are gated by rst_n so a reset landing on a completion cycle drops it.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      addr_nx   = addr;
      wdata_nx  = writedata;
      cpu_ready = 1'b0;
      cpu_rdata = '0;
      memwrite  = 1'b0;
      fill_we   = 1'b0;
      fill_data = writedata;
      if (rst_n) begin
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  if (cpu_we) begin
                     addr_nx  = cpu_addr;
                     wdata_nx = cpu_wdata;
                     cnt_nx   = cnt_t'(1);
                     state_nx = WRITE;
                  end else if (hit) begin
                     cpu_ready = 1'b1;
                     cpu_rdata = line_data;
                  end else begin
                     addr_nx  = cpu_addr;
                     cnt_nx   = cnt_t'(1);
                     state_nx = RMISS;
                  end
               end
            end
            RMISS: begin
               if (last_cycle) begin
                  fill_we   = 1'b1;
                  fill_data = memdata;
                  cpu_rdata = memdata;
                  cpu_ready = 1'b1;
                  state_nx  = IDLE;
               end else begin
                  cnt_nx = cnt + cnt_t'(1);
               end
            end
            WRITE: begin
               if (last_cycle) begin
                  memwrite  = 1'b1;
                  cpu_ready = 1'b1;
                  fill_we   = hit;
                  state_nx  = IDLE;
               end else begin
                  cnt_nx = cnt + cnt_t'(1);
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

endmodule
